mult_req_scheduler: RTL

//  Upstream feeder for the shift-and-add multiplier. Buffers operand pairs in a

---
 rtl/mult_req_scheduler_if.sv | 29 ++
 rtl/mult_req_scheduler.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mult_req_scheduler_if.sv
// Handshake bundle for mult_req_scheduler: operand input, multiplier req/ack, result output.
// The slave modport is the scheduler's view; master is the environment driving it.
interface mult_req_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      in_valid;
  logic [DATA_WIDTH-1:0]     in_a;
  logic [DATA_WIDTH-1:0]     in_b;
  logic                      in_ready;
  logic                      req;
  logic [2*DATA_WIDTH-1:0]   data_req;
  logic                      ack;
  logic [2*DATA_WIDTH-1:0]   data_ack;
  logic                      res_valid;
  logic [2*DATA_WIDTH-1:0]   res_data;
  logic                      res_ready;
  logic                      busy;
  logic                      err;

  modport slave (
    input  in_valid, in_a, in_b, ack, data_ack, res_ready,
    output in_ready, req, data_req, res_valid, res_data, busy, err
  );

  modport master (
    output in_valid, in_a, in_b, ack, data_ack, res_ready,
    input  in_ready, req, data_req, res_valid, res_data, busy, err
  );
endinterface

// File: rtl/mult_req_scheduler.sv
// Operand FIFO feeding a shift-and-add multiplier one request at a time; results go out on valid/ready.
// Optional ack watchdog (TIMEOUT_CYCLES parameter and err flag) enabled by defining MULT_SCHED_TIMEOUT_EN.
module mult_req_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
`ifdef MULT_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_req_scheduler_if.slave  bus
);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  logic [PROD_W-1:0] mem [FIFO_DEPTH];

  state_t            state_reg,     state_next;
  logic [PW-1:0]     wr_ptr_reg,    wr_ptr_next;
  logic [PW-1:0]     rd_ptr_reg,    rd_ptr_next;
  logic [CW-1:0]     count_reg,     count_next;
  logic              in_ready_reg,  in_ready_next;
  logic              req_reg,       req_next;
  logic [PROD_W-1:0] data_req_reg,  data_req_next;
  logic              res_valid_reg, res_valid_next;
  logic [PROD_W-1:0] res_data_reg,  res_data_next;
  logic              push;
  logic              pop;

`ifdef MULT_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]     timer_reg,     timer_next;
  logic              err_reg,       err_next;
`endif

  assign push = bus.in_valid && in_ready_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {bus.in_a, bus.in_b};
    end
  end

  always_comb begin
    state_next     = state_reg;
    req_next       = 1'b0;
    data_req_next  = data_req_reg;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    pop            = 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
    err_next       = err_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (count_reg != '0) begin
          pop           = 1'b1;
          data_req_next = mem[rd_ptr_reg];
          req_next      = 1'b1;
          state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        // An ack in the same cycle as the req pulse cannot belong to this request.
        if (bus.ack && !req_reg) begin
          res_data_next  = bus.data_ack;
          res_valid_next = 1'b1;
          state_next     = S_HOLD;
        end
`ifdef MULT_SCHED_TIMEOUT_EN
        else if (timer_reg == TO_LAST) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
`endif
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          res_valid_next = 1'b0;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    wr_ptr_next   = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    rd_ptr_next   = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    count_next    = count_reg + CW'(push) - CW'(pop);
    in_ready_next = (count_next != FULL_CNT);

`ifdef MULT_SCHED_TIMEOUT_EN
    // Restarts on entry to WAIT, so it measures cycles since the req pulse.
    timer_next = (state_reg == S_WAIT && state_next == S_WAIT) ? timer_reg + TW'(1) : '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      in_ready_reg  <= 1'b1;
      req_reg       <= 1'b0;
      data_req_reg  <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
      timer_reg     <= '0;
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      in_ready_reg  <= in_ready_next;
      req_reg       <= req_next;
      data_req_reg  <= data_req_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
`ifdef MULT_SCHED_TIMEOUT_EN
      timer_reg     <= timer_next;
      err_reg       <= err_next;
`endif
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.req       = req_reg;
  assign bus.data_req  = data_req_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.busy      = (state_reg != S_IDLE) || (count_reg != '0);
`ifdef MULT_SCHED_TIMEOUT_EN
  assign bus.err       = err_reg;
`else
  assign bus.err       = 1'b0;
`endif
endmodule
